// File: rtl/lif_neuron_array_if.sv
// Bundle of control, configuration and status signals for lif_neuron_array.
// The master side requests steps and supplies parameters; the slave side is the neuron array.
interface lif_neuron_array_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned RW        = 8
);
    localparam int unsigned SW = $clog2(N_NEURONS);

    logic                   step_i;
    logic [N_NEURONS*W-1:0] current_i;
    logic [W-1:0]           threshold_i;
    logic [W-1:0]           decay_i;
    logic [RW-1:0]          refrac_i;
    logic                   reset_mode_i;
    logic [SW-1:0]          vmem_sel_i;
    logic [W-1:0]           vmem_o;
    logic                   busy_o;
    logic [N_NEURONS-1:0]   spike_o;
    logic                   spike_valid_o;

    modport master (
        output step_i, current_i, threshold_i, decay_i, refrac_i, reset_mode_i, vmem_sel_i,
        input  vmem_o, busy_o, spike_o, spike_valid_o
    );

    modport slave (
        input  step_i, current_i, threshold_i, decay_i, refrac_i, reset_mode_i, vmem_sel_i,
        output vmem_o, busy_o, spike_o, spike_valid_o
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Each accepted step sweeps all neurons, one per cycle, then strobes the new spike vector.
module lif_neuron_array #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned RW        = 8
) (
    input logic              clk,
    input logic              reset,
    lif_neuron_array_if.slave bus
);
    localparam int unsigned IW = $clog2(N_NEURONS);
    localparam logic [IW-1:0] LastIdx = IW'(N_NEURONS - 1);
    localparam logic signed [W+1:0] VMax = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] VMin = {3'b111, {(W-1){1'b0}}};

    typedef enum logic {StIdle, StSweep} state_e;

    state_e                 r_state, w_state_next;
    logic [IW-1:0]          r_idx;
    logic [W-1:0]           r_vmem [N_NEURONS];
    logic [RW-1:0]          r_cnt  [N_NEURONS];
    logic [N_NEURONS*W-1:0] r_cur;
    logic signed [W-1:0]    r_thr;
    logic [W-1:0]           r_decay;
    logic [RW-1:0]          r_refrac;
    logic                   r_mode;
    logic [N_NEURONS-1:0]   r_acc;
    logic [N_NEURONS-1:0]   r_spike;
    logic                   r_spike_valid;

    logic                   w_accept, w_last;
    logic [W-1:0]           w_v, w_cur;
    logic [RW-1:0]          w_cnt;
    logic signed [W+1:0]    w_v_ext, w_cur_ext, w_dec_ext, w_thr_ext;
    logic signed [W+1:0]    w_tmp, w_leak, w_sum, w_sat;
    logic [W-1:0]           w_diff;
    logic                   w_fire_cond, w_fire;
    logic [W-1:0]           w_v_next;
    logic [RW-1:0]          w_cnt_next;
    logic [N_NEURONS-1:0]   w_acc_final;

    // Control FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.step_i) begin
                    w_accept     = 1'b1;
                    w_state_next = StSweep;
                end
            end
            StSweep: begin
                if (r_idx == LastIdx) begin
                    w_last       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Shared neuron update datapath, working at W+2 bits so sums never wrap
    always_comb begin
        w_v       = r_vmem[r_idx];
        w_cnt     = r_cnt[r_idx];
        w_cur     = r_cur[int'(r_idx)*W +: W];
        w_v_ext   = {{2{w_v[W-1]}}, w_v};
        w_cur_ext = {{2{w_cur[W-1]}}, w_cur};
        w_dec_ext = {2'b00, r_decay};
        w_thr_ext = (r_thr <= 0) ? (W+2)'(1) : {{2{r_thr[W-1]}}, r_thr};

        w_tmp  = '0;
        w_leak = w_v_ext;
        if (w_v_ext > 0) begin
            w_tmp  = w_v_ext - w_dec_ext;
            w_leak = (w_tmp < 0) ? '0 : w_tmp;
        end else if (w_v_ext < 0) begin
            w_tmp  = w_v_ext + w_dec_ext;
            w_leak = (w_tmp > 0) ? '0 : w_tmp;
        end

        w_sum = w_leak + w_cur_ext;
        if (w_sum > VMax)      w_sat = VMax;
        else if (w_sum < VMin) w_sat = VMin;
        else                   w_sat = w_sum;

        w_fire_cond = (w_sat >= w_thr_ext);
        w_diff      = w_sat[W-1:0] - w_thr_ext[W-1:0];

        w_fire     = 1'b0;
        w_v_next   = w_v;
        w_cnt_next = w_cnt;
        if (w_cnt != '0) begin
            w_cnt_next = w_cnt - 1'b1;
        end else if (w_fire_cond) begin
            w_fire     = 1'b1;
            w_cnt_next = r_refrac;
            w_v_next   = r_mode ? '0 : w_diff;
        end else begin
            w_v_next = w_sat[W-1:0];
        end

        w_acc_final        = r_acc;
        w_acc_final[r_idx] = w_fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_cur         <= '0;
            r_thr         <= '0;
            r_decay       <= '0;
            r_refrac      <= '0;
            r_mode        <= 1'b0;
            r_acc         <= '0;
            r_spike       <= '0;
            r_spike_valid <= 1'b0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                r_vmem[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_spike_valid <= w_last;
            if (w_accept) begin
                r_cur    <= bus.current_i;
                r_thr    <= bus.threshold_i;
                r_decay  <= bus.decay_i;
                r_refrac <= bus.refrac_i;
                r_mode   <= bus.reset_mode_i;
                r_acc    <= '0;
                r_idx    <= '0;
            end else if (r_state == StSweep) begin
                r_vmem[r_idx] <= w_v_next;
                r_cnt[r_idx]  <= w_cnt_next;
                r_acc         <= w_acc_final;
                r_idx         <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) r_spike <= w_acc_final;
            end
        end
    end

    assign bus.vmem_o        = r_vmem[bus.vmem_sel_i];
    assign bus.busy_o        = (r_state == StSweep);
    assign bus.spike_o       = r_spike;
    assign bus.spike_valid_o = r_spike_valid;
endmodule
